// File: rtl/uart_lite_seq_if.sv
// AXI4-Lite master/slave bundle between uart_lite_seq and the UART Lite register port.
interface uart_lite_seq_if;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/uart_lite_seq.sv
// AXI4-Lite sequencer for the UART Lite register block: FIFO reset, STAT polling, RX drain, TX push.
// Optional UART_SEQ_IRQ_EN: enable the UART interrupt and poll STAT on uart_irq instead of a timer.
//
// state      | meaning
// INIT       | write CTRL to reset the UART FIFOs
// IDLE       | wait for poll timer / irq, or a pending TX byte
// RD_STAT    | read STAT, latch line errors, choose next action
// RD_RX      | read one byte from the RX FIFO
// WR_TX      | write the held byte to the TX FIFO
module uart_lite_seq #(
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  uart_lite_seq_if.master        m_axi,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic                   uart_irq,
  output logic [3:0]             err_status,
  input  logic                   err_clear,
  output logic                   busy
);

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_RD_STAT = 3'd2;
  localparam logic [2:0] ST_RD_RX   = 3'd3;
  localparam logic [2:0] ST_WR_TX   = 3'd4;

  localparam logic [3:0] A_RX   = 4'h0;
  localparam logic [3:0] A_TX   = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;

`ifdef UART_SEQ_IRQ_EN
  localparam logic [31:0] CTRL_INIT = 32'h0000_0013;
`else
  localparam logic [31:0] CTRL_INIT = 32'h0000_0003;
  localparam int unsigned CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(POLL_INTERVAL - 1);
`endif

  logic [2:0]  state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [3:0]  awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  araddr_q, araddr_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_ready_q, tx_ready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  err_set;
  logic        wr_done, rd_done, busy_w;
  logic        enter_idle, enter_now, poll_due;

  assign wr_done = bready_q & m_axi.bvalid;
  assign rd_done = rready_q & m_axi.rvalid;
  assign busy_w  = awvalid_q | wvalid_q | bready_q | arvalid_q | rready_q;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    err_set     = '0;
    enter_idle  = 1'b0;
    enter_now   = 1'b0;

    // AW and W retire independently; the response phase opens once both are gone
    if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
    if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
    if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) bready_d = 1'b1;
    if (wr_done) begin
      bready_d = 1'b0;
      if (m_axi.bresp != 2'b00) err_set[3] = 1'b1;
    end
    if (arvalid_q && m_axi.arready) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (rd_done) begin
      rready_d = 1'b0;
      if (m_axi.rresp != 2'b00) err_set[3] = 1'b1;
    end

    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (!busy_w) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = A_CTRL;
          wdata_d   = CTRL_INIT;
        end else if (wr_done) begin
          state_d    = ST_IDLE;
          enter_idle = 1'b1;
        end
      end
      ST_IDLE: begin
        if (hold_full_q || poll_due) begin
          state_d   = ST_RD_STAT;
          arvalid_d = 1'b1;
          araddr_d  = A_STAT;
        end
      end
      ST_RD_STAT: begin
        if (rd_done) begin
          err_set[2:0] = m_axi.rdata[7:5];
          if (m_axi.rdata[0] && !rx_valid_q) begin
            state_d   = ST_RD_RX;
            arvalid_d = 1'b1;
            araddr_d  = A_RX;
          end else if (hold_full_q && !m_axi.rdata[3]) begin
            state_d   = ST_WR_TX;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = A_TX;
            wdata_d   = {24'h0, hold_q};
          end else begin
            state_d    = ST_IDLE;
            enter_idle = 1'b1;
          end
        end
      end
      ST_RD_RX: begin
        if (rd_done) begin
          rx_data_d  = m_axi.rdata[7:0];
          rx_valid_d = 1'b1;
          state_d    = ST_IDLE;
          enter_idle = 1'b1;
          enter_now  = 1'b1;
        end
      end
      ST_WR_TX: begin
        if (wr_done) begin
          hold_full_d = 1'b0;
          state_d     = ST_IDLE;
          enter_idle  = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    tx_ready_d = !hold_full_d;
    err_d      = (err_clear ? 4'b0000 : err_q) | err_set;
  end

`ifdef UART_SEQ_IRQ_EN
  logic unused_poll;
  assign poll_due    = uart_irq;
  assign unused_poll = enter_idle ^ enter_now;
`else
  logic [CW-1:0] cnt_q, cnt_d;
  logic          unused_irq;

  assign poll_due   = (cnt_q == '0);
  assign unused_irq = uart_irq;

  // after an RX byte the next STAT poll goes out immediately to keep draining
  always_comb begin
    cnt_d = cnt_q;
    if (enter_idle)
      cnt_d = enter_now ? '0 : CNT_LOAD;
    else if (state_q == ST_IDLE && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end
`endif

  logic unused_rdata;
  assign unused_rdata = ^m_axi.rdata[31:8];

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_INIT;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      err_q       <= err_d;
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'b0001;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign err_status = err_q;
  assign busy       = busy_w;

endmodule

// File: tb/tb_uart_lite_seq.sv
// Directed bench for uart_lite_seq: a table of expected AXI transactions served by a slave model.
module tb_uart_lite_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       uart_irq;
  logic [3:0] err_status;
  logic       err_clear;
  logic       busy;

  uart_lite_seq_if bus ();

  uart_lite_seq #(.POLL_INTERVAL(4)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .m_axi        (bus),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .uart_irq     (uart_irq),
    .err_status   (err_status),
    .err_clear    (err_clear),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } txn_t;

  txn_t vec[$];
  int   vi = 0;
  int   checks = 0;
  int   errors = 0;
  logic txr_at_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [3:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.resp = resp;
    vec.push_back(t);
  endfunction

  // Waits for the next AXI request, compares it with the table entry, completes it.
  task automatic serve();
    txn_t t;
    int   cyc;
    logic is_wr;
    t = vec[vi];
    cyc = 0;
    while (!(bus.awvalid || bus.arvalid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!(bus.awvalid || bus.arvalid)) begin
      check($sformatf("txn%0d_timeout", vi), 0, 1);
      vi++;
      return;
    end
    is_wr = bus.awvalid;
    check($sformatf("txn%0d_is_write", vi), is_wr, t.wr);
    if (is_wr) begin
      check($sformatf("txn%0d_wvalid_with_awvalid", vi), bus.wvalid, 1);
      check($sformatf("txn%0d_awaddr", vi), bus.awaddr, t.addr);
      check($sformatf("txn%0d_wdata", vi), bus.wdata, t.data);
      check($sformatf("txn%0d_wstrb", vi), bus.wstrb, 4'b0001);
      bus.awready = 1'b1; bus.wready = 1'b1;
      @(negedge clk);
      bus.awready = 1'b0; bus.wready = 1'b0;
      check($sformatf("txn%0d_aw_w_dropped", vi), {bus.awvalid, bus.wvalid}, 0);
      cyc = 0;
      while (!bus.bready && cyc < 20) begin @(negedge clk); cyc++; end
      check($sformatf("txn%0d_bready", vi), bus.bready, 1);
      txr_at_b = tx_ready;
      bus.bvalid = 1'b1; bus.bresp = t.resp;
      @(negedge clk);
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
    end else begin
      check($sformatf("txn%0d_araddr", vi), bus.araddr, t.addr);
      bus.arready = 1'b1;
      @(negedge clk);
      bus.arready = 1'b0;
      cyc = 0;
      while (!bus.rready && cyc < 20) begin @(negedge clk); cyc++; end
      check($sformatf("txn%0d_rready", vi), bus.rready, 1);
      bus.rvalid = 1'b1; bus.rdata = t.data; bus.rresp = t.resp;
      @(negedge clk);
      bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    end
    vi++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) serve();
  endtask

  task automatic load_tx(input logic [7:0] b);
    check("tx_ready_before_load", tx_ready, 1);
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_load", tx_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; uart_irq = 1'b0; err_clear = 1'b0;

    add(1, 4'hC, 32'h3,  2'b00);  // 0  INIT CTRL write
    add(0, 4'h8, 32'h0,  2'b00);  // 1  first STAT
    add(0, 4'h8, 32'h01, 2'b00);  // 2  RX not empty
    add(0, 4'h0, 32'h41, 2'b00);  // 3  RX read
    add(0, 4'h8, 32'h01, 2'b00);  // 4  rx_valid held: no RX read
    add(0, 4'h8, 32'h00, 2'b00);  // 5
    add(0, 4'h8, 32'h04, 2'b00);  // 6  TX empty
    add(1, 4'h4, 32'h5A, 2'b00);  // 7  TX write
    add(0, 4'h8, 32'h08, 2'b00);  // 8  TX full x3
    add(0, 4'h8, 32'h08, 2'b00);  // 9
    add(0, 4'h8, 32'h08, 2'b00);  // 10
    add(0, 4'h8, 32'h04, 2'b00);  // 11
    add(1, 4'h4, 32'h5A, 2'b00);  // 12 retried TX write
    add(0, 4'h8, 32'hE0, 2'b00);  // 13 all line errors
    add(0, 4'h8, 32'h04, 2'b00);  // 14
    add(1, 4'h4, 32'h33, 2'b10);  // 15 SLVERR on write
    add(0, 4'h8, 32'h20, 2'b10);  // 16 error with err_clear held
    add(0, 4'h8, 32'h04, 2'b00);  // 17 leads to write interrupted by reset
    add(1, 4'hC, 32'h3,  2'b00);  // 18 INIT repeats after reset
    add(0, 4'h8, 32'h0,  2'b00);  // 19

    repeat (3) @(negedge clk);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err_status, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // 1: CTRL write then STAT poll
    run(2);
    check("t1_busy_idle", busy, 0);
    check("t1_tx_ready", tx_ready, 1);
    check("t1_rx_valid", rx_valid, 0);

    // 2: RX byte, held until rx_ready; no further RX read while held
    run(2);
    check("t2_rx_valid", rx_valid, 1);
    check("t2_rx_data", rx_data, 8'h41);
    run(2);
    check("t2_rx_valid_held", rx_valid, 1);
    check("t2_rx_data_held", rx_data, 8'h41);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("t2_rx_valid_cleared", rx_valid, 0);

    // 3: TX byte written; tx_ready low until the write response
    load_tx(8'h5A);
    run(2);
    check("t3_tx_ready_at_bvalid", txr_at_b, 0);
    check("t3_tx_ready_after", tx_ready, 1);

    // 4: TX FIFO full three times, written on the 4th poll
    load_tx(8'h5A);
    run(5);
    check("t4_tx_ready_after", tx_ready, 1);

    // 5: sticky errors, clear, and set-wins-over-clear
    run(1);
    check("t5_err_line", err_status, 4'b0111);
    load_tx(8'h33);
    run(2);
    check("t5_err_bresp", err_status, 4'b1111);
    check("t5_tx_ready_after_err", tx_ready, 1);
    err_clear = 1'b1;
    @(negedge clk);
    check("t5_err_cleared", err_status, 4'b0000);
    run(1);
    check("t5_err_set_wins", err_status, 4'b1001);
    err_clear = 1'b0;

    // 6: reset during a pending write
    load_tx(8'h77);
    run(1);
    cyc = 0;
    while (!bus.awvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("t6_awvalid_pending", bus.awvalid, 1);
    check("t6_busy_pending", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_awvalid", bus.awvalid, 0);
    check("t6_rst_wvalid", bus.wvalid, 0);
    check("t6_rst_arvalid", bus.arvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err_status, 0);
    check("t6_rst_tx_ready", tx_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    check("t6_tx_ready_after", tx_ready, 1);
    check("t6_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
